// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: redirect/stall controls in, instruction memory port and decode stage out.
// The master side is the sequencer; the slave side is the branch unit, memory and decode.
`timescale 1ns/1ps
interface fetch_sequencer_if;
   logic        branch;
   logic        bypass;
   logic        flush;
   logic        hold;
   logic [31:0] PCnext;
   logic [31:0] PCcurrent;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] PCIF;
   logic        validIF;
   logic [31:0] instrDEC;
   logic [31:0] PCDEC;
   logic        validDEC;
   logic        misaligned;

   modport master (
      input  branch, bypass, flush, hold, PCnext, PCcurrent, imem_rdata,
      output imem_en, imem_addr, PCIF, validIF, instrDEC, PCDEC, validDEC, misaligned
   );

   modport slave (
      output branch, bypass, flush, hold, PCnext, PCcurrent, imem_rdata,
      input  imem_en, imem_addr, PCIF, validIF, instrDEC, PCDEC, validDEC, misaligned
   );
endinterface

// File: rtl/fetch_sequencer.sv
// PC generator plus IF/DEC register; address reaches DEC 2 cycles later, a redirect costs 2 bubbles.
// hold freezes PC, IF and DEC and re-fetches the IF word; redirect and flush override hold.
`timescale 1ns/1ps
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               Clock,
   input  logic               Reset,
   fetch_sequencer_if.master  bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pcif_q, pcif_d;
   logic        validif_q, validif_d;
   logic [31:0] instr_dec_q, instr_dec_d;
   logic [31:0] pc_dec_q, pc_dec_d;
   logic        valid_dec_q, valid_dec_d;
   logic        misaligned_q, misaligned_d;

   logic        redirect;
   logic        stall;
   logic [31:0] target_raw;
   logic [31:0] fetch_addr;

   always_comb begin
      redirect   = bus.bypass | bus.branch;
      stall      = bus.hold & ~redirect & ~bus.flush;
      target_raw = bus.bypass ? {bus.PCnext[31:1], 1'b0} : (bus.PCcurrent + bus.PCnext);
      // During a stall the word already in IF is fetched again so it is still on rdata at release.
      fetch_addr = stall ? pcif_q : pc_q;
   end

   always_comb begin
      pc_d         = pc_q + 32'd4;
      pcif_d       = fetch_addr;
      validif_d    = 1'b1;
      instr_dec_d  = validif_q ? bus.imem_rdata : NOP_INSTR;
      pc_dec_d     = validif_q ? pcif_q : 32'd0;
      valid_dec_d  = validif_q;
      misaligned_d = 1'b0;

      if (redirect) begin
         pc_d         = {target_raw[31:2], 2'b00};
         validif_d    = 1'b0;
         instr_dec_d  = NOP_INSTR;
         pc_dec_d     = 32'd0;
         valid_dec_d  = 1'b0;
         misaligned_d = target_raw[1];
      end else if (bus.flush) begin
         instr_dec_d  = NOP_INSTR;
         pc_dec_d     = 32'd0;
         valid_dec_d  = 1'b0;
      end else if (bus.hold) begin
         pc_d         = pc_q;
         validif_d    = validif_q;
         instr_dec_d  = instr_dec_q;
         pc_dec_d     = pc_dec_q;
         valid_dec_d  = valid_dec_q;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc_q         <= RESET_PC;
         pcif_q       <= 32'd0;
         validif_q    <= 1'b0;
         instr_dec_q  <= NOP_INSTR;
         pc_dec_q     <= 32'd0;
         valid_dec_q  <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         pcif_q       <= pcif_d;
         validif_q    <= validif_d;
         instr_dec_q  <= instr_dec_d;
         pc_dec_q     <= pc_dec_d;
         valid_dec_q  <= valid_dec_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign bus.imem_en    = ~Reset;
   assign bus.imem_addr  = fetch_addr;
   assign bus.PCIF       = pcif_q;
   assign bus.validIF    = validif_q;
   assign bus.instrDEC   = instr_dec_q;
   assign bus.PCDEC      = pc_dec_q;
   assign bus.validDEC   = valid_dec_q;
   assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instruction-stream model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] MEM_KEY   = 32'hA5A5_0000;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ MEM_KEY;
   endfunction

   // Synchronous 1-cycle memory
   always @(posedge Clock)
      if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: next fetch PC, the fetch in flight, and the instruction in decode.
   logic [31:0] m_pc = 32'd0, m_if_addr = 32'd0, m_dec_pc = 32'd0;
   logic        m_if_vld = 1'b0, m_dec_vld = 1'b0, m_mis = 1'b0, m_init = 1'b0;

   function automatic logic [31:0] target_of(input logic byp, input logic [31:0] cur, input logic [31:0] nxt);
      return byp ? (nxt & ~32'd1) : (cur + nxt);
   endfunction

   always @(posedge Clock) begin
      if (Reset) begin
         m_init    <= 1'b1;
         m_pc      <= RESET_PC;
         m_if_addr <= 32'd0;
         m_if_vld  <= 1'b0;
         m_dec_pc  <= 32'd0;
         m_dec_vld <= 1'b0;
         m_mis     <= 1'b0;
      end else if (m_init) begin
         if (bus.bypass || bus.branch) begin
            m_mis     <= target_of(bus.bypass, bus.PCcurrent, bus.PCnext) >> 1;
            m_pc      <= target_of(bus.bypass, bus.PCcurrent, bus.PCnext) & ~32'd3;
            m_if_addr <= m_pc;
            m_if_vld  <= 1'b0;
            m_dec_pc  <= 32'd0;
            m_dec_vld <= 1'b0;
         end else begin
            m_mis <= 1'b0;
            if (bus.flush) begin
               m_dec_pc  <= 32'd0;
               m_dec_vld <= 1'b0;
            end else if (!bus.hold) begin
               m_dec_pc  <= m_if_vld ? m_if_addr : 32'd0;
               m_dec_vld <= m_if_vld;
            end
            if (bus.flush || !bus.hold) begin
               m_if_addr <= m_pc;
               m_if_vld  <= 1'b1;
               m_pc      <= m_pc + 32'd4;
            end
         end
      end
   end

   always @(negedge Clock) begin
      if (m_init) begin
         chk("m.imem_en", 32'(bus.imem_en), 32'(!Reset));
         chk("m.imem_addr", bus.imem_addr,
             (bus.hold && !bus.bypass && !bus.branch && !bus.flush) ? m_if_addr : m_pc);
         chk("m.PCIF", bus.PCIF, m_if_addr);
         chk("m.validIF", 32'(bus.validIF), 32'(m_if_vld));
         chk("m.PCDEC", bus.PCDEC, m_dec_pc);
         chk("m.validDEC", 32'(bus.validDEC), 32'(m_dec_vld));
         chk("m.instrDEC", bus.instrDEC, m_dec_vld ? mem_word(m_dec_pc) : NOP_INSTR);
         chk("m.misaligned", 32'(bus.misaligned), 32'(m_mis & 1'b1));
      end
   end

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic drv(input logic byp, input logic br, input logic fl, input logic ho,
                      input logic [31:0] cur, input logic [31:0] nxt);
      bus.bypass = byp; bus.branch = br; bus.flush = fl; bus.hold = ho;
      bus.PCcurrent = cur; bus.PCnext = nxt;
   endtask

   initial begin
      drv(0, 0, 0, 0, 32'd0, 32'd0);
      bus.imem_rdata = 32'd0;
      repeat (3) cyc();
      // Sequential fetch
      Reset = 1'b0;                                          // c0
      @(negedge Clock);
      chk("c0.imem_en", 32'(bus.imem_en), 32'd1);
      chk("c0.imem_addr", bus.imem_addr, 32'h0);
      chk("c0.validIF", 32'(bus.validIF), 32'd0);
      chk("c0.instrDEC", bus.instrDEC, 32'h13);
      cyc(); @(negedge Clock);                               // c1
      chk("c1.PCIF", bus.PCIF, 32'h0);
      chk("c1.validIF", 32'(bus.validIF), 32'd1);
      chk("c1.imem_addr", bus.imem_addr, 32'h4);
      cyc(); @(negedge Clock);                               // c2
      chk("c2.PCDEC", bus.PCDEC, 32'h0);
      chk("c2.validDEC", 32'(bus.validDEC), 32'd1);
      chk("c2.instrDEC", bus.instrDEC, 32'hA5A5_0000);
      cyc(); @(negedge Clock);                               // c3
      chk("c3.PCDEC", bus.PCDEC, 32'h4);
      // Hold three cycles with PC 8 in decode
      cyc(); drv(0, 0, 0, 1, 0, 0); @(negedge Clock);        // c4
      chk("c4.PCDEC", bus.PCDEC, 32'h8);
      chk("c4.imem_addr", bus.imem_addr, 32'hC);
      for (int i = 5; i <= 6; i++) begin
         cyc(); @(negedge Clock);
         chk("hold.PCDEC", bus.PCDEC, 32'h8);
         chk("hold.imem_addr", bus.imem_addr, 32'hC);
      end
      cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge Clock);        // c7
      chk("c7.PCDEC", bus.PCDEC, 32'h8);
      chk("c7.imem_addr", bus.imem_addr, 32'h10);
      cyc(); @(negedge Clock);                               // c8
      chk("c8.PCDEC", bus.PCDEC, 32'hC);
      chk("c8.instrDEC", bus.instrDEC, 32'hA5A5_000C);
      // Relative redirect 0x20 + (-16) = 0x10
      cyc(); drv(0, 1, 0, 0, 32'h20, 32'hFFFF_FFF0); @(negedge Clock); // c9
      chk("c9.PCDEC", bus.PCDEC, 32'h10);
      chk("c9.instrDEC", bus.instrDEC, 32'hA5A5_0010);
      cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge Clock);        // c10
      chk("c10.imem_addr", bus.imem_addr, 32'h10);
      chk("c10.validIF", 32'(bus.validIF), 32'd0);
      chk("c10.validDEC", 32'(bus.validDEC), 32'd0);
      chk("c10.misaligned", 32'(bus.misaligned), 32'd0);
      cyc(); @(negedge Clock);                               // c11
      chk("c11.validDEC", 32'(bus.validDEC), 32'd0);
      chk("c11.PCIF", bus.PCIF, 32'h10);
      cyc(); @(negedge Clock);                               // c12
      chk("c12.PCDEC", bus.PCDEC, 32'h10);
      chk("c12.validDEC", 32'(bus.validDEC), 32'd1);
      // Bypass beats branch; 0x103 -> 0x100 with misaligned pulse
      drv(1, 1, 0, 0, 32'h20, 32'h0000_0103);
      cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge Clock);        // c13
      chk("c13.imem_addr", bus.imem_addr, 32'h100);
      chk("c13.misaligned", 32'(bus.misaligned), 32'd1);
      cyc(); @(negedge Clock);                               // c14
      chk("c14.misaligned", 32'(bus.misaligned), 32'd0);
      chk("c14.PCIF", bus.PCIF, 32'h100);
      cyc(); drv(0, 0, 1, 1, 0, 0); @(negedge Clock);        // c15: flush+hold
      chk("c15.PCDEC", bus.PCDEC, 32'h100);
      chk("c15.imem_addr", bus.imem_addr, 32'h108);
      cyc(); drv(0, 0, 0, 0, 0, 0); @(negedge Clock);        // c16
      chk("c16.validDEC", 32'(bus.validDEC), 32'd0);
      chk("c16.instrDEC", bus.instrDEC, 32'h13);
      chk("c16.PCIF", bus.PCIF, 32'h108);
      cyc(); drv(0, 1, 0, 0, 32'h40, 32'h8); @(negedge Clock); // c17
      chk("c17.PCDEC", bus.PCDEC, 32'h108);
      // Reset in the cycle after a branch
      cyc(); drv(0, 0, 0, 0, 0, 0); Reset = 1'b1;            // c18
      cyc(); Reset = 1'b0; @(negedge Clock);                 // c19
      chk("c19.imem_addr", bus.imem_addr, 32'h0);
      chk("c19.PCIF", bus.PCIF, 32'h0);
      chk("c19.validIF", 32'(bus.validIF), 32'd0);
      chk("c19.validDEC", 32'(bus.validDEC), 32'd0);
      chk("c19.PCDEC", bus.PCDEC, 32'h0);
      chk("c19.instrDEC", bus.instrDEC, 32'h13);
      cyc(); @(negedge Clock);                               // c20
      chk("c20.validDEC", 32'(bus.validDEC), 32'd0);
      cyc(); @(negedge Clock);                               // c21
      chk("c21.PCDEC", bus.PCDEC, 32'h0);
      chk("c21.validDEC", 32'(bus.validDEC), 32'd1);
      // Mixed directed run, checked by the model only
      drv(0, 1, 0, 0, 32'hFFFF_FFF0, 32'h22);  cyc();        // wrap, target 0x12 -> 0x10, misaligned
      drv(0, 0, 0, 1, 0, 0);                  cyc();        // hold during squash
      drv(0, 0, 0, 0, 0, 0);                  repeat (3) cyc();
      drv(0, 0, 1, 0, 0, 0);                  cyc();        // flush alone
      drv(0, 0, 0, 1, 0, 0);                  cyc();
      drv(1, 0, 0, 1, 0, 32'h0000_0201);      cyc();        // bypass with hold, 0x200
      drv(0, 0, 0, 0, 0, 0);                  repeat (3) cyc();
      drv(0, 1, 1, 1, 32'h300, 32'h6);        cyc();        // branch over flush/hold, misaligned
      drv(0, 0, 0, 0, 0, 0);                  repeat (2) cyc();
      drv(0, 0, 0, 1, 0, 0);                  repeat (2) cyc();
      drv(0, 0, 0, 0, 0, 0);                  repeat (3) cyc();
      Reset = 1'b1;                           repeat (2) cyc();
      @(negedge Clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
